// File: rtl/drive_seq_pkg.sv
// drive_seq_pkg: shared types and constants for drive_sequencer.
// Phase state enum, p_drive dead-pattern bit, tweak_delay width.
// Optional feature macro (used by importers): DRIVE_SEQ_TIMEOUT_EN.
package drive_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    TWEAK = 2'd2,
    HOLD  = 2'd3
  } seq_state_e;

  localparam int unsigned DLY_W = 8;

  // Every p_drive bit at this value means "pull-up off".
  localparam logic P_OFF = 1'b1;

  function automatic logic [DLY_W-1:0] dly_dec(
    input logic [DLY_W-1:0] v
  );
    return v - DLY_W'(1);
  endfunction

endpackage

// File: rtl/drive_sequencer_tweak_timer.sv
// tweak_timer: phase state machine with delay and timeout counters.
// Ports: clk_i, rst_ni (sync, active-low), dead_i, delay_i[7:0];
//        tweak_en_o (enable for the edge being sampled now),
//        phase_active_o (registered, high outside IDLE).
// Macro DRIVE_SEQ_TIMEOUT_EN: TWEAK -> HOLD after TWEAK_MAX cycles.
module tweak_timer
  import drive_seq_pkg::*;
#(
  parameter int unsigned TWEAK_MAX = 200
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             dead_i,
  input  logic [DLY_W-1:0] delay_i,
  output logic             tweak_en_o,
  output logic             phase_active_o
);

  seq_state_e       state_q, state_d;
  logic [DLY_W-1:0] dcnt_q, dcnt_d;

`ifdef DRIVE_SEQ_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TWEAK_MAX + 2);
  localparam logic [TW-1:0] TMAX = TW'(TWEAK_MAX);
  logic [TW-1:0] tcnt_q, tcnt_d;
`else
  logic unused_tweak_max;
  assign unused_tweak_max = |TWEAK_MAX;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      dcnt_q  <= '0;
`ifdef DRIVE_SEQ_TIMEOUT_EN
      tcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
`ifdef DRIVE_SEQ_TIMEOUT_EN
      tcnt_q  <= tcnt_d;
`endif
    end
  end

  // tcnt counts enabled edges; the entry edge is number 1.
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
`ifdef DRIVE_SEQ_TIMEOUT_EN
    tcnt_d  = tcnt_q;
`endif
    if (dead_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (delay_i == '0) begin
            state_d = TWEAK;
`ifdef DRIVE_SEQ_TIMEOUT_EN
            tcnt_d  = TW'(1);
`endif
          end else begin
            state_d = DELAY;
            dcnt_d  = delay_i;
          end
        end
        DELAY: begin
          if (dcnt_q == DLY_W'(1)) begin
            state_d = TWEAK;
`ifdef DRIVE_SEQ_TIMEOUT_EN
            tcnt_d  = TW'(1);
`endif
          end else begin
            dcnt_d = dly_dec(dcnt_q);
          end
        end
        TWEAK: begin
`ifdef DRIVE_SEQ_TIMEOUT_EN
          if (tcnt_q >= TMAX) begin
            state_d = HOLD;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
`endif
        end
        HOLD: begin
          state_d = HOLD;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Enable tracks the state being entered so that D=0
  // drives tweaks at the phase-start edge itself.
  always_comb begin
    tweak_en_o     = (state_d == TWEAK);
    phase_active_o = (state_q != IDLE);
  end

endmodule

// File: rtl/drive_sequencer.sv
// drive_sequencer: registered gate stage with tweak timing and
// per-leg break-before-make interlock. Dead input = phase delimiter.
// Ports: clk, reset_n (sync, active-low), p_drive, n_drive,
//        tweak_delay, tweak_sense, tweak_drive -> p_gate, n_gate,
//        tweak_p, tweak_n, fault (sticky), phase_active.
// Macro DRIVE_SEQ_TIMEOUT_EN enables the TWEAK_MAX tweak timeout.
module drive_sequencer
  import drive_seq_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned NTWEAK    = 6,
  parameter int unsigned TWEAK_MAX = 200
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [WIDTH-1:0]        p_drive,
  input  logic [WIDTH-1:0]        n_drive,
  input  logic [DLY_W-1:0]        tweak_delay,
  input  logic [WIDTH-1:0]        tweak_sense,
  input  logic [NTWEAK*WIDTH-1:0] tweak_drive,
  output logic [WIDTH-1:0]        p_gate,
  output logic [WIDTH-1:0]        n_gate,
  output logic [NTWEAK*WIDTH-1:0] tweak_p,
  output logic [NTWEAK*WIDTH-1:0] tweak_n,
  output logic [WIDTH-1:0]        fault,
  output logic                    phase_active
);

  localparam int unsigned TWW = NTWEAK * WIDTH;

  logic [WIDTH-1:0] p_gate_q, p_gate_d;
  logic [WIDTH-1:0] n_gate_q, n_gate_d;
  logic [TWW-1:0]   tp_q, tp_d;
  logic [TWW-1:0]   tn_q, tn_d;
  logic [WIDTH-1:0] fault_q, fault_d;

  logic             dead;
  logic             tweak_en;
  logic [TWW-1:0]   req_tp, req_tn;
  logic [WIDTH-1:0] up_req, dn_req;
  logic [WIDTH-1:0] up_prev, dn_prev;
  logic [WIDTH-1:0] viol;

  assign dead = (p_drive == {WIDTH{P_OFF}})
             && (n_drive == '0)
             && (tweak_sense == '0)
             && (tweak_delay == '0)
             && (tweak_drive == '0);

  tweak_timer #(
    .TWEAK_MAX (TWEAK_MAX)
  ) u_timer (
    .clk_i          (clk),
    .rst_ni         (reset_n),
    .dead_i         (dead),
    .delay_i        (tweak_delay),
    .tweak_en_o     (tweak_en),
    .phase_active_o (phase_active)
  );

  // Requested drive this cycle, folded per leg.
  always_comb begin
    req_tp = '1;
    req_tn = '0;
    up_req = ~p_drive;
    dn_req = n_drive;
    for (int k = 0; k < NTWEAK; k++) begin
      if (tweak_en) begin
        req_tp[k*WIDTH +: WIDTH] =
          ~(tweak_drive[k*WIDTH +: WIDTH] & tweak_sense);
        req_tn[k*WIDTH +: WIDTH] =
          tweak_drive[k*WIDTH +: WIDTH] & ~tweak_sense;
      end
      up_req = up_req | ~req_tp[k*WIDTH +: WIDTH];
      dn_req = dn_req | req_tn[k*WIDTH +: WIDTH];
    end
  end

  // Direction currently driven by the registered outputs.
  always_comb begin
    up_prev = ~p_gate_q;
    dn_prev = n_gate_q;
    for (int k = 0; k < NTWEAK; k++) begin
      up_prev = up_prev | ~tp_q[k*WIDTH +: WIDTH];
      dn_prev = dn_prev | tn_q[k*WIDTH +: WIDTH];
    end
  end

  // Shoot-through or reversal without an off cycle blanks the leg.
  assign viol = (up_req & dn_req)
              | (up_req & dn_prev)
              | (dn_req & up_prev);

  always_comb begin
    p_gate_d = p_drive | viol;
    n_gate_d = n_drive & ~viol;
    tp_d     = req_tp;
    tn_d     = req_tn;
    for (int k = 0; k < NTWEAK; k++) begin
      tp_d[k*WIDTH +: WIDTH] = req_tp[k*WIDTH +: WIDTH] | viol;
      tn_d[k*WIDTH +: WIDTH] = req_tn[k*WIDTH +: WIDTH] & ~viol;
    end
    fault_d = fault_q | viol;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      p_gate_q <= '1;
      n_gate_q <= '0;
      tp_q     <= '1;
      tn_q     <= '0;
      fault_q  <= '0;
    end else begin
      p_gate_q <= p_gate_d;
      n_gate_q <= n_gate_d;
      tp_q     <= tp_d;
      tn_q     <= tn_d;
      fault_q  <= fault_d;
    end
  end

  assign p_gate  = p_gate_q;
  assign n_gate  = n_gate_q;
  assign tweak_p = tp_q;
  assign tweak_n = tn_q;
  assign fault   = fault_q;

endmodule

// File: tb/tb_drive_sequencer.sv
// tb_drive_sequencer: self-checking bench for drive_sequencer.
// Reference model tracks phases by elapsed edge count since phase start.
module tb_drive_sequencer;

  localparam int W    = 8;
  localparam int NT   = 6;
  localparam int TMAX = 4;
  localparam int TWW  = NT * W;
  localparam int OW   = 3 * W + 2 * TWW + 1;
  localparam logic [OW-1:0] RST_OBS =
    {8'hFF, 8'h00, {TWW{1'b1}}, {TWW{1'b0}}, 8'h00, 1'b0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset_n;
  logic [W-1:0]   p_drive, n_drive, tweak_sense;
  logic [7:0]     tweak_delay;
  logic [TWW-1:0] tweak_drive;
  logic [W-1:0]   p_gate, n_gate, fault;
  logic [TWW-1:0] tweak_p, tweak_n;
  logic           phase_active;

  int checks = 0;
  int errors = 0;

  logic [W-1:0]   m_p, m_n, m_fault;
  logic [TWW-1:0] m_tp, m_tn;
  logic           m_pa;
  bit             m_in;
  int             m_start, m_d, edge_n;

  logic [OW-1:0] obs, expv;
  assign obs  = {p_gate, n_gate, tweak_p, tweak_n, fault, phase_active};
  assign expv = {m_p, m_n, m_tp, m_tn, m_fault, m_pa};

  drive_sequencer #(
    .WIDTH     (W),
    .NTWEAK    (NT),
    .TWEAK_MAX (TMAX)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .p_drive      (p_drive),
    .n_drive      (n_drive),
    .tweak_delay  (tweak_delay),
    .tweak_sense  (tweak_sense),
    .tweak_drive  (tweak_drive),
    .p_gate       (p_gate),
    .n_gate       (n_gate),
    .tweak_p      (tweak_p),
    .tweak_n      (tweak_n),
    .fault        (fault),
    .phase_active (phase_active)
  );

  task automatic model_step();
    logic [W-1:0]   np, nn, nf;
    logic [TWW-1:0] ntp, ntn;
    bit dead, en, up, dn, pu, pd, d;
    int el;
    edge_n++;
    if (!reset_n) begin
      m_p = '1; m_n = '0; m_tp = '1; m_tn = '0;
      m_fault = '0; m_pa = 1'b0; m_in = 0;
      return;
    end
    dead = (p_drive == 8'hFF) && (n_drive == 0) &&
           (tweak_sense == 0) && (tweak_delay == 0) &&
           (tweak_drive == 0);
    en = 0;
    if (dead) m_in = 0;
    else begin
      if (!m_in) begin
        m_in = 1;
        m_start = edge_n;
        m_d = int'(tweak_delay);
      end
      el = edge_n - m_start;
      en = (el >= m_d);
`ifdef DRIVE_SEQ_TIMEOUT_EN
      if (el - m_d >= TMAX) en = 0;
`endif
    end
    np = p_drive; nn = n_drive; nf = m_fault;
    ntp = '1; ntn = '0;
    if (en)
      for (int k = 0; k < NT; k++)
        for (int i = 0; i < W; i++) begin
          d = tweak_drive[k*W+i];
          ntp[k*W+i] = !(d && tweak_sense[i]);
          ntn[k*W+i] = d && !tweak_sense[i];
        end
    for (int i = 0; i < W; i++) begin
      up = !np[i]; dn = nn[i];
      pu = !m_p[i]; pd = m_n[i];
      for (int k = 0; k < NT; k++) begin
        up = up || !ntp[k*W+i];
        dn = dn || ntn[k*W+i];
        pu = pu || !m_tp[k*W+i];
        pd = pd || m_tn[k*W+i];
      end
      if ((up && dn) || (up && pd) || (dn && pu)) begin
        np[i] = 1'b1; nn[i] = 1'b0; nf[i] = 1'b1;
        for (int k = 0; k < NT; k++) begin
          ntp[k*W+i] = 1'b1;
          ntn[k*W+i] = 1'b0;
        end
      end
    end
    m_p = np; m_n = nn; m_tp = ntp; m_tn = ntn;
    m_fault = nf; m_pa = m_in;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_dead();
    p_drive = 8'hFF; n_drive = '0; tweak_sense = '0;
    tweak_delay = '0; tweak_drive = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      p_drive = 8'h00; n_drive = 8'($urandom);
      tweak_sense = 8'($urandom); tweak_delay = 8'd0;
      tweak_drive = {$urandom, $urandom};
      tick();
      checks++;
      if (obs !== RST_OBS) begin
        errors++;
        $display("FAIL reset c%0d got %h want %h", c, obs, RST_OBS);
      end
    end
    reset_n = 1'b1;
    set_dead();
    tick();
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL reset_rel got %h want %h", obs, expv);
    end
  endtask

  task automatic test_delay();
    set_dead();
    tick();
    p_drive = 8'h0F; tweak_delay = 8'd3; tweak_sense = 8'hFF;
    tweak_drive = '0; tweak_drive[7:0] = 8'h0F;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (p_gate !== 8'h0F || phase_active !== 1'b1) begin
        errors++;
        $display("FAIL delay_main c%0d got %h/%b want 0f/1",
                 c, p_gate, phase_active);
      end
      checks++;
      if (tweak_p[7:0] !== ((c >= 3) ? 8'hF0 : 8'hFF)) begin
        errors++;
        $display("FAIL delay_tw c%0d got %h", c, tweak_p[7:0]);
      end
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL delay_mdl c%0d got %h want %h", c, obs, expv);
      end
    end
  endtask

  task automatic test_cancel();
    set_dead();
    tick();
    p_drive = 8'hFF; n_drive = '0;
    tweak_sense = 8'($urandom); tweak_delay = 8'd5;
    tweak_drive = {$urandom, $urandom} | 48'h1;
    for (int c = 0; c < 8; c++) begin
      if (c == 2) set_dead();
      tick();
      checks++;
      if (tweak_p !== {TWW{1'b1}} || tweak_n !== '0 ||
          phase_active !== (c < 2)) begin
        errors++;
        $display("FAIL cancel c%0d tp %h tn %h pa %b",
                 c, tweak_p, tweak_n, phase_active);
      end
    end
  endtask

  task automatic test_interlock();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    set_dead();
    tick();
    p_drive = 8'hFE;
    tick();
    p_drive = 8'hFF; n_drive = 8'h01;
    tick();
    checks++;
    if (p_gate !== 8'hFF || n_gate !== 8'h00 || fault !== 8'h01) begin
      errors++;
      $display("FAIL ilk_block p %h n %h f %h want ff/00/01",
               p_gate, n_gate, fault);
    end
    tick();
    checks++;
    if (n_gate !== 8'h01 || fault !== 8'h01) begin
      errors++;
      $display("FAIL ilk_after n %h f %h want 01/01", n_gate, fault);
    end
    set_dead();
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (fault !== 8'h01 || obs !== expv) begin
        errors++;
        $display("FAIL ilk_sticky f %h want 01", fault);
      end
    end
    reset_n = 1'b0;
    tick();
    checks++;
    if (fault !== 8'h00) begin
      errors++;
      $display("FAIL ilk_clear f %h want 00", fault);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_zero_delay();
    set_dead();
    tick();
    tweak_sense = 8'h00; tweak_delay = 8'd0;
    tweak_drive = '0; tweak_drive[23:16] = 8'h80;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (tweak_n[23:16] !== 8'h80 || phase_active !== 1'b1 ||
          obs !== expv) begin
        errors++;
        $display("FAIL zero c%0d tn2 %h pa %b", c,
                 tweak_n[23:16], phase_active);
      end
    end
  endtask

  task automatic test_timeout();
    int act, want;
    set_dead();
    tick();
    tweak_sense = 8'hAA; tweak_delay = 8'd2;
    tweak_drive = '0; tweak_drive[15:8] = 8'hFF;
    act = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (tweak_p !== {TWW{1'b1}} || tweak_n !== '0) act++;
      checks++;
      if (phase_active !== 1'b1 || obs !== expv) begin
        errors++;
        $display("FAIL tmo_cyc c%0d got %h want %h", c, obs, expv);
      end
    end
`ifdef DRIVE_SEQ_TIMEOUT_EN
    want = TMAX;
`else
    want = 10;
`endif
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL tmo_count got %0d want %0d", act, want);
    end
  endtask

  task automatic test_d255();
    int first;
    set_dead();
    tick();
    tweak_sense = 8'($urandom); tweak_delay = 8'd255;
    tweak_drive = '0; tweak_drive[7:0] = 8'($urandom) | 8'h01;
    first = -1;
    for (int c = 0; c < 258; c++) begin
      tick();
      if (first < 0 && (tweak_p !== {TWW{1'b1}} || tweak_n !== '0))
        first = c;
    end
    checks++;
    if (first !== 255) begin
      errors++;
      $display("FAIL d255 first %0d want 255", first);
    end
  endtask

  task automatic test_random();
    int r;
    for (int c = 0; c < 600; c++) begin
      r = $urandom_range(0, 99);
      reset_n = (r >= 2);
      if (r < 12) set_dead();
      else begin
        p_drive = ~(8'($urandom) & 8'($urandom) & 8'($urandom));
        n_drive = 8'($urandom) & 8'($urandom) & 8'($urandom);
        tweak_sense = 8'($urandom);
        tweak_delay = ($urandom_range(0, 9) == 0) ?
                      8'($urandom) : 8'($urandom_range(0, 4));
        tweak_drive = {$urandom, $urandom} & {$urandom, $urandom}
                    & {$urandom, $urandom};
      end
      tick();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL random c%0d got %h want %h", c, obs, expv);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    set_dead();
    edge_n = 0; m_in = 0; m_start = 0; m_d = 0;
    m_p = '1; m_n = '0; m_tp = '1; m_tn = '0;
    m_fault = '0; m_pa = 1'b0;
    test_reset();
    test_delay();
    test_cancel();
    test_interlock();
    test_zero_delay();
    test_timeout();
    test_d255();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/drive_sequencer.md
# drive_sequencer

Output stage between the pattern buffer and the pad drivers. Consumes the per-cycle drive and tweak bytes, enforces break-before-make per leg, times the tweak legs against phase start using the programmed tweak delay, and registers all gate controls. Dead time arrives from upstream as an all-off pattern, and this block uses it as the phase delimiter.

## Interface
- `WIDTH`, 8: legs per drive word (one bit per leg)
- `NTWEAK`, 6: tweak drive words consumed (0..NTWEAK-1)
- `TWEAK_MAX`, 200: tweak on-time limit in cycles (used only with `DRIVE_SEQ_TIMEOUT_EN`)

Ports:
- `clk`  in  1  clock
- `reset_n`  in  1  reset, synchronous, active-low
- `p_drive`  in  WIDTH  pull-up enables, active-low (all ones = off)
- `n_drive`  in  WIDTH  pull-down enables, active-high
- `tweak_delay`  in  8  cycles from phase start to tweak enable
- `tweak_sense`  in  WIDTH  per leg: 1 = tweak pulls up, 0 = tweak pulls down
- `tweak_drive`  in  NTWEAK*WIDTH  concatenated tweak words, word k at [k*WIDTH +: WIDTH]
- `p_gate`  out  WIDTH  registered pull-up gates, active-low
- `n_gate`  out  WIDTH  registered pull-down gates, active-high
- `tweak_p`  out  NTWEAK*WIDTH  tweak pull-up gates, active-low
- `tweak_n`  out  NTWEAK*WIDTH  tweak pull-down gates, active-high
- `fault`  out  WIDTH  sticky per-leg interlock violation flags
- `phase_active`  out  1  high in DELAY, TWEAK and HOLD

## Operation
- Dead pattern: `p_drive` all ones, `n_drive`=0, `tweak_sense`=0, `tweak_delay`=0, all `tweak_drive`=0. Any other input word is non-dead.
- States: IDLE, DELAY, TWEAK, HOLD.
  - IDLE: on a non-dead input, capture `tweak_delay` as D. D=0 → TWEAK; otherwise DELAY with counter=D.
  - DELAY: decrement the counter; at 1 → TWEAK.
  - TWEAK: tweak outputs follow the inputs. On timeout → HOLD.
  - HOLD: tweaks forced off.
  - Any state: a dead input → IDLE. This has priority over every other transition.
- `tweak_delay` is sampled only at phase start. Changes mid-phase are ignored.
- Main gates pass through registered every cycle in every state. The dead pattern yields all off.
- Tweak mapping when enabled, per word k and leg i:
  - `tweak_p[k][i]` = ~(`tweak_drive[k][i]` & `tweak_sense[i]`)
  - `tweak_n[k][i]` = `tweak_drive[k][i]` & ~`tweak_sense[i]`
  - When not enabled: `tweak_p` all ones, `tweak_n` 0.
- Interlock, per leg i. A leg is "pulling up" if `p_gate` or any `tweak_p` bit is low, and "pulling down" if `n_gate` or any `tweak_n` bit is high.
  - A leg may pull down only if its registered outputs were not pulling up in the previous cycle, and the reverse.
  - A request that pulls up and down in the same cycle, or reverses direction with no off cycle, forces all of that leg's outputs off for that cycle and sets `fault[i]`.
- `fault` clears only on reset.

## Timing
- Reset values: `p_gate` all ones, `n_gate` 0, `tweak_p` all ones, `tweak_n` 0, `fault` 0, `phase_active` 0, state IDLE.
- Main gate latency is 1 cycle: input at edge k appears at the outputs after edge k.
- First non-dead input at edge k:
  - D=0: tweaks active from edge k.
  - D>0: tweaks first active at edge k+D.
- `phase_active` rises at edge k and falls at the edge that samples the dead input.
- Dead input during DELAY cancels the pending tweak. No tweak output appears.
- `reset_n` low mid-phase: at that edge all outputs return to reset values, and the counters and captured D are discarded.
- D=255 is legal. Counter width is 8 bits with no wrap.

## Configuration
- Macro `DRIVE_SEQ_TIMEOUT_EN`.
  - Defined: a cycle counter in TWEAK moves the block to HOLD after exactly `TWEAK_MAX` active cycles, forcing tweaks off until the next dead pattern.
  - Undefined: HOLD is unreachable and tweaks persist until the dead pattern. `TWEAK_MAX` is ignored.

## Structure
- Shared package `drive_seq_pkg`: state enum (IDLE, DELAY, TWEAK, HOLD), the dead-pattern constant for `p_drive`, and the `tweak_delay` width constant.
- One sub-module, `tweak_timer`: the state machine plus the delay and timeout counters, outputting `tweak_en` and `phase_active`. Gate mapping and the interlock stay in the top level.

## Test plan
- Reset: hold `reset_n`=0 with non-dead inputs → `p_gate`=8'hFF, `n_gate`=0, tweaks off, `fault`=0.
- Delay: dead, then `p_drive`=8'h0F, `tweak_delay`=3, `tweak_sense`=8'hFF, word0=8'h0F → `p_gate`=8'h0F one cycle later; `tweak_p` word0=8'hF0 from the third edge after phase start.
- Cancel: D=5, dead pattern at the 2nd DELAY cycle → no tweak activity; state IDLE.
- Interlock: `p_drive`=8'hFE then next cycle `n_drive`=8'h01 with `p_drive`=8'hFF → leg 0 all off for one cycle, `fault`=8'h01 persisting until reset.
- Zero delay: D=0, `tweak_sense`=0, word2=8'h80 → `tweak_n` word2=8'h80 at the phase-start edge.
- Timeout, with the macro and `TWEAK_MAX`=4: tweaks active exactly 4 cycles then off, `phase_active` remains 1; without the macro, tweaks stay on until dead.
